// File: rtl/riscv_data_apb_bridge.sv
`default_nettype none
// =============================================================================
// riscv_data_apb_bridge
// Bridges the RISC-V data-access port onto a multi-target APB4 bus with
// target decode, write strobes, an access timeout and error capture.
// Revision: 1.0
// =============================================================================
module riscv_data_apb_bridge #(
    parameter int NUM_TARGETS    = 4,
    parameter int TARGET_SEL_LSB = 18,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        clk__enable,
    input  logic                        reset_n,
    input  logic [31:0]                 data_access_req__address,
    input  logic [3:0]                  data_access_req__byte_enable,
    input  logic                        data_access_req__write_enable,
    input  logic                        data_access_req__read_enable,
    input  logic [31:0]                 data_access_req__write_data,
    output logic                        data_access_resp__wait,
    output logic [31:0]                 data_access_resp__read_data,
    output logic [31:0]                 apb_request__paddr,
    output logic [NUM_TARGETS-1:0]      apb_request__psel,
    output logic                        apb_request__penable,
    output logic                        apb_request__pwrite,
    output logic [31:0]                 apb_request__pwdata,
    output logic [3:0]                  apb_request__pstrb,
    input  logic [NUM_TARGETS*32-1:0]   apb_response__prdata,
    input  logic [NUM_TARGETS-1:0]      apb_response__pready,
    input  logic [NUM_TARGETS-1:0]      apb_response__perr,
    output logic                        error_valid,
    output logic [1:0]                  error_cause,
    output logic [31:0]                 error_address
);

    localparam int SEL_BITS = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam int CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [SEL_BITS:0] TGT_LIMIT = (SEL_BITS + 1)'(NUM_TARGETS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DECERR = 2'd3
    } state_t;

    state_t                 state_q;
    logic [NUM_TARGETS-1:0] psel_q;
    logic                   penable_q;
    logic                   pwrite_q;
    logic [31:0]            paddr_q;
    logic [31:0]            pwdata_q;
    logic [3:0]             pstrb_q;
    logic [31:0]            addr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   error_valid_q;
    logic [1:0]             error_cause_q;
    logic [31:0]            error_address_q;

    logic                   w_req;
    logic [SEL_BITS-1:0]    w_target;
    logic                   w_decerr;
    logic [NUM_TARGETS-1:0] w_sel_onehot;
    logic [31:0]            w_prdata;
    logic                   w_ready;
    logic                   w_perr;
    logic                   w_timeout;
    logic                   w_wait;
    logic [31:0]            w_rdata;
    logic                   w_err;
    logic [1:0]             w_cause;

    assign w_req     = data_access_req__read_enable | data_access_req__write_enable;
    assign w_target  = data_access_req__address[TARGET_SEL_LSB +: SEL_BITS];
    assign w_decerr  = ({1'b0, w_target} >= TGT_LIMIT);

    // Response muxing keys off the registered one-hot select, so no index decode is needed.
    always_comb begin
        w_sel_onehot = '0;
        w_prdata     = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            w_sel_onehot[i] = (w_target == SEL_BITS'(i));
            if (psel_q[i]) begin
                w_prdata = w_prdata | apb_response__prdata[32*i +: 32];
            end
        end
    end

    assign w_ready   = |(apb_response__pready & psel_q);
    assign w_perr    = |(apb_response__perr & psel_q);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        w_wait  = 1'b0;
        w_rdata = '0;
        w_err   = 1'b0;
        w_cause = 2'b00;
        case (state_q)
            ST_IDLE:   w_wait = w_req;
            ST_SETUP:  w_wait = 1'b1;
            ST_ACCESS: begin
                if (w_ready) begin
                    w_rdata = pwrite_q ? 32'h0 : w_prdata;
                    if (w_perr) begin
                        w_err   = 1'b1;
                        w_cause = 2'b10;
                    end
                end else if (w_timeout) begin
                    w_err   = 1'b1;
                    w_cause = 2'b11;
                end else begin
                    w_wait = 1'b1;
                end
            end
            ST_DECERR: begin
                w_err   = 1'b1;
                w_cause = 2'b01;
            end
            default: w_wait = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            psel_q          <= '0;
            penable_q       <= 1'b0;
            pwrite_q        <= 1'b0;
            paddr_q         <= '0;
            pwdata_q        <= '0;
            pstrb_q         <= '0;
            addr_q          <= '0;
            cnt_q           <= '0;
            error_valid_q   <= 1'b0;
            error_cause_q   <= 2'b00;
            error_address_q <= '0;
        end else if (clk__enable) begin
            error_valid_q <= w_err;
            if (w_err) begin
                error_cause_q   <= w_cause;
                error_address_q <= addr_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (w_req) begin
                        addr_q <= data_access_req__address;
                        if (w_decerr) begin
                            state_q <= ST_DECERR;
                        end else begin
                            state_q  <= ST_SETUP;
                            psel_q   <= w_sel_onehot;
                            paddr_q  <= 32'(data_access_req__address[TARGET_SEL_LSB-1:2]);
                            pwrite_q <= data_access_req__write_enable;
                            pwdata_q <= data_access_req__write_data;
                            pstrb_q  <= data_access_req__write_enable ? data_access_req__byte_enable : 4'b0000;
                        end
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                end
                ST_ACCESS: begin
                    if (w_ready || w_timeout) begin
                        state_q   <= ST_IDLE;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DECERR: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_access_resp__wait      = w_wait;
    assign data_access_resp__read_data = w_rdata;
    assign apb_request__paddr          = paddr_q;
    assign apb_request__psel           = psel_q;
    assign apb_request__penable        = penable_q;
    assign apb_request__pwrite         = pwrite_q;
    assign apb_request__pwdata         = pwdata_q;
    assign apb_request__pstrb          = pstrb_q;
    assign error_valid                 = error_valid_q;
    assign error_cause                 = error_cause_q;
    assign error_address               = error_address_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_data_apb_bridge.sv
`default_nettype none
// =============================================================================
// tb_riscv_data_apb_bridge
// Directed bench: a transaction-timeline model predicts every output each cycle.
// Revision: 1.0
// =============================================================================
module tb_riscv_data_apb_bridge;

    localparam int NT  = 3;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        clk_en;
    logic        reset_n;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic        req_we;
    logic        req_re;
    logic [31:0] req_wd;
    logic        resp_wait;
    logic [31:0] resp_rdata;
    logic [31:0] paddr;
    logic [NT-1:0] psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [NT*32-1:0] prdata;
    logic [NT-1:0] pready;
    logic [NT-1:0] perr;
    logic        err_valid;
    logic [1:0]  err_cause;
    logic [31:0] err_addr;

    riscv_data_apb_bridge #(
        .NUM_TARGETS   (NT),
        .TARGET_SEL_LSB(18),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                          (clk),
        .clk__enable                  (clk_en),
        .reset_n                      (reset_n),
        .data_access_req__address     (req_addr),
        .data_access_req__byte_enable (req_be),
        .data_access_req__write_enable(req_we),
        .data_access_req__read_enable (req_re),
        .data_access_req__write_data  (req_wd),
        .data_access_resp__wait       (resp_wait),
        .data_access_resp__read_data  (resp_rdata),
        .apb_request__paddr           (paddr),
        .apb_request__psel            (psel),
        .apb_request__penable         (penable),
        .apb_request__pwrite          (pwrite),
        .apb_request__pwdata          (pwdata),
        .apb_request__pstrb           (pstrb),
        .apb_response__prdata         (prdata),
        .apb_response__pready         (pready),
        .apb_response__perr           (perr),
        .error_valid                  (err_valid),
        .error_cause                  (err_cause),
        .error_address                (err_addr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected per-cycle outputs
    bit          chk_en = 1'b0;
    logic        exp_wait = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [NT-1:0] exp_psel = '0;
    logic        exp_pen = 1'b0;
    logic [31:0] exp_paddr = '0;
    logic        exp_pwrite = 1'b0;
    logic [31:0] exp_pwdata = '0;
    logic [3:0]  exp_pstrb = '0;
    logic        exp_ev = 1'b0;
    logic [1:0]  exp_cause = '0;
    logic [31:0] exp_eaddr = '0;

    // Error reported in the current cycle, to appear on the error outputs next cycle
    bit          m_pend = 1'b0;
    logic [1:0]  m_pc = '0;
    logic [31:0] m_pa = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wait", 32'(resp_wait), 32'(exp_wait));
            chk("read_data", resp_rdata, exp_rdata);
            chk("psel", 32'(psel), 32'(exp_psel));
            chk("penable", 32'(penable), 32'(exp_pen));
            chk("error_valid", 32'(err_valid), 32'(exp_ev));
            chk("error_cause", 32'(err_cause), 32'(exp_cause));
            chk("error_address", err_addr, exp_eaddr);
            if (exp_psel != '0) begin
                chk("paddr", paddr, exp_paddr);
                chk("pwrite", 32'(pwrite), 32'(exp_pwrite));
                chk("pwdata", pwdata, exp_pwdata);
                chk("pstrb", 32'(pstrb), 32'(exp_pstrb));
            end
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
        exp_ev = m_pend;
        if (m_pend) begin
            exp_cause = m_pc;
            exp_eaddr = m_pa;
        end
        m_pend = 1'b0;
    endtask

    // Selected target responds as asked; every other target shouts ready/err with junk data
    task automatic drive_resp(input int t, input bit rdy, input bit er, input logic [31:0] rd);
        for (int i = 0; i < NT; i++) begin
            if (i == t) begin
                pready[i] = rdy;
                perr[i]   = er;
                prdata[32*i +: 32] = rd;
            end else begin
                pready[i] = 1'b1;
                perr[i]   = 1'b1;
                prdata[32*i +: 32] = 32'hBAD0_0000 | 32'(i);
            end
        end
    endtask

    task automatic idle_cycle();
        adv();
        req_re = 1'b0;
        req_we = 1'b0;
        drive_resp(NT, 1'b0, 1'b0, 32'h0);
        exp_wait  = 1'b0;
        exp_rdata = '0;
        exp_psel  = '0;
        exp_pen   = 1'b0;
    endtask

    // d = number of ACCESS cycles before pready; returns in the completion cycle
    task automatic run_txn(input logic [31:0] addr, input bit we, input bit re_too,
                           input logic [3:0] be, input logic [31:0] wd, input int d,
                           input bit er, input logic [31:0] rd);
        int t;
        bit fin;
        t = int'(addr[19:18]);
        adv();
        req_addr = addr;
        req_be   = be;
        req_we   = we;
        req_re   = !we || re_too;
        req_wd   = wd;
        drive_resp(t, 1'b0, 1'b0, rd);
        exp_wait  = 1'b1;
        exp_rdata = '0;
        exp_psel  = '0;
        exp_pen   = 1'b0;
        if (t >= NT) begin
            adv();
            exp_wait = 1'b0;
            m_pend = 1'b1; m_pc = 2'b01; m_pa = addr;
            return;
        end
        adv();
        exp_psel   = NT'(1 << t);
        exp_paddr  = {16'h0, addr[17:2]};
        exp_pwrite = we;
        exp_pwdata = wd;
        exp_pstrb  = we ? be : 4'b0000;
        fin = 1'b0;
        for (int k = 0; !fin && k < 64; k++) begin
            adv();
            exp_pen = 1'b1;
            if (k == d) begin
                drive_resp(t, 1'b1, er, rd);
                exp_wait  = 1'b0;
                exp_rdata = we ? 32'h0 : rd;
                if (er) begin
                    m_pend = 1'b1; m_pc = 2'b10; m_pa = addr;
                end
                fin = 1'b1;
            end else begin
                drive_resp(t, 1'b0, 1'b0, rd);
                if (k == TMO - 1) begin
                    exp_wait  = 1'b0;
                    exp_rdata = '0;
                    m_pend = 1'b1; m_pc = 2'b11; m_pa = addr;
                    fin = 1'b1;
                end else begin
                    exp_wait = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        clk_en   = 1'b1;
        reset_n  = 1'b0;
        req_addr = '0; req_be = '0; req_we = 1'b0; req_re = 1'b0; req_wd = '0;
        prdata   = '0; pready = '0; perr = '0;

        @(negedge clk);
        @(negedge clk);
        chk("reset_psel", 32'(psel), 32'h0);
        chk("reset_penable", 32'(penable), 32'h0);
        chk("reset_paddr", paddr, 32'h0);
        chk("reset_pwrite", 32'(pwrite), 32'h0);
        chk("reset_pwdata", pwdata, 32'h0);
        chk("reset_pstrb", 32'(pstrb), 32'h0);
        chk("reset_error_valid", 32'(err_valid), 32'h0);
        chk("reset_error_cause", 32'(err_cause), 32'h0);
        chk("reset_error_address", err_addr, 32'h0);
        chk("reset_wait", 32'(resp_wait), 32'h0);

        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        idle_cycle();
        idle_cycle();

        // Plain read, target 0, ready in first ACCESS
        run_txn(32'h0000_0010, 1'b0, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
        @(negedge clk);
        chk("pin_read_data", resp_rdata, 32'hCAFE_F00D);
        chk("pin_paddr_read", paddr, 32'h0000_0004);

        // Write to target 1 with both enables set, ready after 3 wait states
        run_txn(32'h0004_0008, 1'b1, 1'b1, 4'b0011, 32'h1234_5678, 3, 1'b0, 32'h0BAD_BEEF);
        @(negedge clk);
        chk("pin_pstrb", 32'(pstrb), 32'h3);
        chk("pin_paddr_write", paddr, 32'h0000_0002);
        chk("pin_psel_write", 32'(psel), 32'h2);
        idle_cycle();

        // Decode error: target 3 does not exist
        run_txn(32'h000C_0000, 1'b0, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'h0);
        idle_cycle();
        @(negedge clk);
        chk("pin_decerr_valid", 32'(err_valid), 32'h1);
        chk("pin_decerr_cause", 32'(err_cause), 32'h1);
        chk("pin_decerr_addr", err_addr, 32'h000C_0000);

        // Target 2 never ready: timeout
        run_txn(32'h0008_0100, 1'b0, 1'b0, 4'hF, 32'h0, 1000, 1'b0, 32'h1111_2222);
        idle_cycle();
        @(negedge clk);
        chk("pin_timeout_cause", 32'(err_cause), 32'h3);
        chk("pin_timeout_psel", 32'(psel), 32'h0);

        // pready+perr, then an immediate clean read
        run_txn(32'h0000_0020, 1'b0, 1'b0, 4'hF, 32'h0, 1, 1'b1, 32'h0000_DEAD);
        @(negedge clk);
        chk("pin_perr_rdata", resp_rdata, 32'h0000_DEAD);
        run_txn(32'h0004_0020, 1'b0, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'h5555_AAAA);
        @(negedge clk);
        chk("pin_after_perr_rdata", resp_rdata, 32'h5555_AAAA);
        chk("pin_perr_cause", 32'(err_cause), 32'h2);

        // Ready arrives exactly on the last allowed ACCESS cycle: ready wins
        run_txn(32'h0008_0004, 1'b0, 1'b0, 4'hF, 32'h0, TMO - 1, 1'b0, 32'h0000_0077);
        idle_cycle();

        // Reset during ACCESS
        adv();
        req_addr = 32'h0004_0040; req_re = 1'b1; req_we = 1'b0; req_wd = '0;
        drive_resp(1, 1'b0, 1'b0, 32'h0000_0011);
        exp_wait = 1'b1; exp_rdata = '0; exp_psel = '0; exp_pen = 1'b0;
        adv();
        exp_psel = 3'b010; exp_paddr = 32'h0000_0010; exp_pwrite = 1'b0;
        exp_pwdata = '0; exp_pstrb = '0;
        adv();
        exp_pen = 1'b1;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        chk_en  = 1'b0;
        #1;
        chk("async_rst_psel", 32'(psel), 32'h0);
        chk("async_rst_penable", 32'(penable), 32'h0);
        chk("async_rst_wait", 32'(resp_wait), 32'h1);
        chk("async_rst_error_cause", 32'(err_cause), 32'h0);
        chk("async_rst_error_address", err_addr, 32'h0);
        req_re = 1'b0;
        m_pend = 1'b0; exp_ev = 1'b0; exp_cause = '0; exp_eaddr = '0;
        exp_psel = '0; exp_pen = 1'b0; exp_wait = 1'b0; exp_rdata = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;

        run_txn(32'h0004_0044, 1'b0, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'hA5A5_0001);
        @(negedge clk);
        chk("pin_post_reset_rdata", resp_rdata, 32'hA5A5_0001);
        idle_cycle();
        idle_cycle();
        @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_data_apb_bridge.md
Name: riscv_data_apb_bridge

Overview:
Parametrised bridge from the RISC-V core data-access port (data_access_req/data_access_resp) to an APB bus with multiple targets. Decodes the target from address bits and drives one psel per target. Adds APB4 strobes, a timeout, and error capture. Sits between riscv_i32_minimal (or successors) and APB peripherals such as apb_target_timer.

Parameters:
NUM_TARGETS, 4, number of APB targets (1..16); SEL_BITS = clog2(NUM_TARGETS), min 1
TARGET_SEL_LSB, 18, lowest address bit of target index; paddr = address[TARGET_SEL_LSB-1:2] zero-extended to 32
TIMEOUT_CYCLES, 255, max ACCESS cycles without pready before abort; 0 disables timeout

Ports:
clk  in  1  clock
clk__enable  in  1  clock enable; all state holds when low
reset_n  in  1  asynchronous active-low reset
data_access_req__address  in  32  byte address
data_access_req__byte_enable  in  4  byte lanes
data_access_req__write_enable  in  1  write request
data_access_req__read_enable  in  1  read request
data_access_req__write_data  in  32  write data
data_access_resp__wait  out  1  combinational; high until access completes
data_access_resp__read_data  out  32  combinational; valid when wait low in completion cycle
apb_request__paddr  out  32  word address
apb_request__psel  out  NUM_TARGETS  one-hot target select
apb_request__penable  out  1  APB enable
apb_request__pwrite  out  1  write
apb_request__pwdata  out  32  write data
apb_request__pstrb  out  4  byte_enable on writes, 0 on reads
apb_response__prdata  in  NUM_TARGETS*32  per-target read data, target i at [32i+31:32i]
apb_response__pready  in  NUM_TARGETS  per-target ready
apb_response__perr  in  NUM_TARGETS  per-target error
error_valid  out  1  registered one-cycle pulse after an errored completion
error_cause  out  2  01 decode, 10 perr, 11 timeout; held until next error
error_address  out  32  request byte address of last error; held

Behaviour:
- Clock and reset: one clock clk; reset_n is asynchronous, active low. Reset: state IDLE, psel 0, penable 0, paddr/pwdata/pstrb 0, pwrite 0, timeout counter 0, error_valid 0, error_cause 0, error_address 0. Reset mid-transfer abandons it immediately; the requester must re-issue.
- Request = read_enable|write_enable; both set is treated as write. Request must be held stable while wait is high.
- target = address[TARGET_SEL_LSB +: SEL_BITS]; decode error if target >= NUM_TARGETS.
- FSM IDLE -> SETUP -> ACCESS -> IDLE; IDLE -> DECERR -> IDLE.
- IDLE: wait = request. Valid target: register paddr, pwrite, pwdata, pstrb and target; go SETUP. Decode error: go DECERR; no psel.
- SETUP: psel[target]=1, penable=0, wait=1; go ACCESS; clear counter.
- ACCESS: psel[target]=1, penable=1. If pready[target]=1: wait=0, read_data=prdata[target] (0 for writes); go IDLE with psel/penable low next cycle. If perr[target] is also high, it is an error completion (cause 10).
- Timeout: counter increments each ACCESS cycle without pready. The abort occurs when the counter reaches TIMEOUT_CYCLES-1 and pready is still low: wait=0, read_data=0, cause 11, go IDLE.
- DECERR: wait=0, read_data=0, cause 01; go IDLE.
- Outside completion cycles, read_data = 0.
- Minimum latency: wait high 2 cycles, completes in 3rd (SETUP, ACCESS). Back-to-back requests are accepted in IDLE the cycle after completion.
- Error capture: on error completion in cycle N, cycle N+1 has error_valid=1 and cause/address updated. pready and timeout in the same cycle: pready wins.

Test Plan:
- Read target 0 at 0x0000_0010, pready in first ACCESS, prdata0=0xCAFEF00D -> paddr=0x4, psel=0001, wait high 2 cycles, read_data=0xCAFEF00D on 3rd cycle, error_valid stays 0.
- Write 0x0004_0008 be=0011 data 0x1234_5678 (target 1), pready delayed 3 cycles -> psel=0010, pwrite=1, pstrb=0011, paddr=0x2, penable high 4 cycles, wait low on pready cycle.
- NUM_TARGETS=3, access 0x000C_0000 (target 3) -> no psel asserted, wait high 1 cycle then low, read_data=0, next cycle error_valid=1, cause=01, error_address=0x000C_0000.
- TIMEOUT_CYCLES=8, target never ready -> abort after 8 ACCESS cycles, read_data=0, cause=11; psel low next cycle.
- Read with pready and perr both high, prdata=0xDEAD -> read_data=0xDEAD, cause=10; then an immediate following read completes normally.
- Assert reset_n low in ACCESS -> psel/penable drop asynchronously and state returns to IDLE; after release a new read completes in 3 cycles.
